// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM fader: channel mode and breathe ramp direction.
package led_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } breathe_st_t;

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: shadow/active config, optional breathe ramp (LED_PWM_BREATHE_EN), PWM compare.
//   state   | meaning
//   BR_UP   | ramp level rising toward duty, one step per PWM period
//   BR_DOWN | ramp level falling toward 0, one step per PWM period
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [PWM_W-1:0] i_duty,
    input  mode_t            i_mode,
    input  logic             i_bound,
    input  logic [PWM_W-1:0] i_pwm,
    input  logic             i_blink_msb,
    output logic             o_led
);

    localparam logic [PWM_W-1:0] LVL_MAX = '1;

    logic [PWM_W-1:0] r_sh_duty;
    logic [PWM_W-1:0] r_act_duty;
    mode_t            r_sh_mode;
    mode_t            r_act_mode;
    logic [PWM_W-1:0] w_level;
    logic             w_on;

    // Active config only moves at a period boundary so a duty change never cuts a pulse short.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_duty  <= '0;
            r_sh_mode  <= MODE_OFF;
            r_act_duty <= '0;
            r_act_mode <= MODE_OFF;
        end else begin
            if (i_we) begin
                r_sh_duty <= i_duty;
                r_sh_mode <= i_mode;
            end
            if (i_bound) begin
                r_act_duty <= r_sh_duty;
                r_act_mode <= r_sh_mode;
            end
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [PWM_W-1:0] r_ramp;
    breathe_st_t      r_st;

    // A mode change landing at this boundary restarts the ramp from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ramp <= '0;
            r_st   <= BR_UP;
        end else if (i_bound) begin
            if (r_sh_mode != r_act_mode) begin
                r_ramp <= '0;
                r_st   <= BR_UP;
            end else if (r_act_mode == MODE_BREATHE) begin
                unique case (r_st)
                    BR_UP: begin
                        if (r_ramp < r_act_duty) r_ramp <= r_ramp + 1'b1;
                        else                     r_st   <= BR_DOWN;
                    end
                    BR_DOWN: begin
                        if (r_ramp != '0) r_ramp <= r_ramp - 1'b1;
                        else              r_st   <= BR_UP;
                    end
                endcase
            end
        end
    end
`endif

    always_comb begin
        w_level = '0;
        unique case (r_act_mode)
            MODE_OFF:     w_level = '0;
            MODE_STATIC:  w_level = r_act_duty;
            MODE_BLINK:   w_level = i_blink_msb ? '0 : r_act_duty;
`ifdef LED_PWM_BREATHE_EN
            MODE_BREATHE: w_level = r_ramp;
`else
            MODE_BREATHE: w_level = r_act_duty;
`endif
        endcase
    end

    // Full-scale level means solid on; otherwise the counter never reaches all-ones inside the pulse.
    assign w_on = (w_level == LVL_MAX) || (i_pwm < w_level);

    always_ff @(posedge i_clk) begin
        if (i_rst) o_led <= ACTIVE_LOW;
        else       o_led <= w_on ^ ACTIVE_LOW;
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM fader: shared prescaler/PWM/blink timebase, per-channel write decode.
// Breathe ramp compiled in only when LED_PWM_BREATHE_EN is defined.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE   = 16,
    parameter int BLINK_W    = 6,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_wr_ch,
    input  logic [PWM_W-1:0]                            i_wr_duty,
    input  logic [MODE_W-1:0]                           i_wr_mode,
    output logic [NUM_CH-1:0]                           o_led,
    output logic                                        o_period
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = '1;

    logic [PS_W-1:0]    r_presc;
    logic [PWM_W-1:0]   r_pwm;
    logic [BLINK_W-1:0] r_blink;
    logic               w_tick;
    logic               w_bound;

    assign w_tick  = (r_presc == PS_LAST);
    assign w_bound = w_tick && (r_pwm == PWM_LAST);
    assign o_period = w_bound && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
            r_blink <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)  r_pwm   <= r_pwm + 1'b1;
            if (w_bound) r_blink <= r_blink + 1'b1;
        end
    end

    // Channel indices at or above NUM_CH match no instance, so those writes vanish.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_we;
        assign w_we = i_wr_en && (i_wr_ch == CH_W'(g));

        led_pwm_channel #(
            .PWM_W      (PWM_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_we        (w_we),
            .i_duty      (i_wr_duty),
            .i_mode      (mode_t'(i_wr_mode)),
            .i_bound     (w_bound),
            .i_pwm       (r_pwm),
            .i_blink_msb (r_blink[BLINK_W-1]),
            .o_led       (o_led[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader (3 ch, 4-bit PWM, prescale 2, 32-cycle period); polarity pair DUTs.
module tb_led_pwm_fader;

    localparam int PER = 32;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr_en = 1'b0;
    logic [1:0] i_wr_ch = '0;
    logic [3:0] i_wr_duty = '0;
    logic [1:0] i_wr_mode = '0;
    logic [2:0] o_led, o_led_al;
    logic       o_period, o_period_al;

    always #5 i_clk = ~i_clk;

    led_pwm_fader #(.NUM_CH(3), .PWM_W(4), .PRESCALE(2), .BLINK_W(3), .ACTIVE_LOW(1'b0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch),
        .i_wr_duty(i_wr_duty), .i_wr_mode(i_wr_mode), .o_led(o_led), .o_period(o_period));

    led_pwm_fader #(.NUM_CH(3), .PWM_W(4), .PRESCALE(2), .BLINK_W(3), .ACTIVE_LOW(1'b1)) dut_al (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch),
        .i_wr_duty(i_wr_duty), .i_wr_mode(i_wr_mode), .o_led(o_led_al), .o_period(o_period_al));

    typedef struct {
        int ch;
        int mode;
        int duty;
        int e0;
        int e1;
        int e2;
    } vec_t;

    vec_t vt[8];
    int   exp_bl[12];
    int   exp_br[12];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_on[3];
    int   m_on_al[3];
    int   cyc;
    int   dark;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int ch, input int mode, input int duty);
        i_wr_en   = 1'b1;
        i_wr_ch   = 2'(ch);
        i_wr_mode = 2'(mode);
        i_wr_duty = 4'(duty);
        @(negedge i_clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic wait_period(input string name, output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_period && n < 64);
        if (!o_period) check({name, " period timeout"}, 0, 1);
    endtask

    task automatic measure(input int skip);
        for (int c = 0; c < 3; c++) begin
            m_on[c] = 0;
            m_on_al[c] = 0;
        end
        repeat (skip) @(negedge i_clk);
        repeat (PER) begin
            @(negedge i_clk);
            for (int c = 0; c < 3; c++) begin
                m_on[c]    += int'(o_led[c]);
                m_on_al[c] += int'(o_led_al[c]);
            end
        end
    endtask

    task automatic check_win(input string tag, input int e0, input int e1, input int e2);
        int e[3];
        e = '{e0, e1, e2};
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s ch%0d", tag, c), m_on[c], e[c]);
            check($sformatf("%s ch%0d act-low", tag, c), m_on_al[c], PER - e[c]);
        end
    endtask

    initial begin
        // {ch, mode, duty, on-cycles per period for ch0/ch1/ch2}, cumulative state
        vt[0] = '{0, 1, 4,  8,  0,  0};
        vt[1] = '{0, 1, 15, 32, 0,  0};
        vt[2] = '{0, 1, 0,  0,  0,  0};
        vt[3] = '{1, 1, 7,  0,  14, 0};
        vt[4] = '{2, 1, 1,  0,  14, 2};
        vt[5] = '{3, 1, 15, 0,  14, 2};
        vt[6] = '{1, 0, 9,  0,  0,  2};
        vt[7] = '{0, 1, 14, 28, 0,  2};
        exp_bl = '{32, 32, 32, 0, 0, 0, 0, 32, 32, 32, 32, 0};
`ifdef LED_PWM_BREATHE_EN
        exp_br = '{0, 2, 4, 6, 6, 4, 2, 0, 0, 2, 4, 6};
`else
        exp_br = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
`endif

        // Writes issued while reset is held must be dropped.
        @(negedge i_clk);
        wr(0, 1, 15);
        wr(1, 2, 9);
        @(negedge i_clk);
        check("reset o_led", int'(o_led), 0);
        check("reset o_led act-low", int'(o_led_al), 7);
        check("reset o_period", int'(o_period), 0);
        i_rst = 1'b0;

        wait_period("first", cyc);
        check("first boundary after release", cyc, 31);
        repeat (2) begin
            wait_period("gap", cyc);
            check("period spacing", cyc, 32);
        end
        measure(1);
        check_win("idle after reset", 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            wr(vt[i].ch, vt[i].mode, vt[i].duty);
            wait_period($sformatf("vec%0d", i), cyc);
            measure(1);
            check_win($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].e2);
        end

        // Write landing in the boundary cycle waits a full extra period.
        wait_period("bnd write", cyc);
        wr(0, 1, 8);
        measure(0);
        check_win("bnd write old duty", 28, 0, 2);
        measure(0);
        check_win("bnd write new duty", 16, 0, 2);

        // Start a breathe ramp, then reset in the middle of it.
        wr(2, 3, 3);
        repeat (3) wait_period("ramp", cyc);
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid-ramp reset o_led", int'(o_led), 0);
        check("mid-ramp reset o_led act-low", int'(o_led_al), 7);
        check("mid-ramp reset o_period", int'(o_period), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        wr(0, 1, 4);
        wr(1, 2, 15);
        wr(2, 3, 3);
        cyc = 3;
        dark = 0;
        while (!o_period && cyc < 64) begin
            if (o_led != 3'b000 || o_led_al != 3'b111) dark++;
            @(negedge i_clk);
            cyc++;
        end
        check("post-reset channels off", dark, 0);
        check("post-reset first boundary", cyc, 31);

        for (int k = 0; k < 12; k++) begin
            measure((k == 0) ? 1 : 0);
            check_win($sformatf("seq period %0d", k + 1), 8, exp_bl[k], exp_br[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent LED channels, 1..16.
REQ-002 Parameter PWM_W, default 8: duty/PWM counter width in bits, 2..12.
REQ-003 Parameter PRESCALE, default 16: i_clk cycles per PWM counter step, >=1.
REQ-004 Parameter BLINK_W, default 6: blink period-counter width; on/off phase = 2^(BLINK_W-1) PWM periods each.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 inverts every o_led bit.
REQ-006 i_clk  input  1  clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_wr_en  input  1  single-cycle channel configuration write strobe; always accepted, no backpressure.
REQ-009 i_wr_ch  input  max(1,$clog2(NUM_CH))  target channel index.
REQ-010 i_wr_duty  input  PWM_W  target duty level.
REQ-011 i_wr_mode  input  2  mode: 0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE.
REQ-012 o_led  output  NUM_CH  registered LED drive, one bit per channel.
REQ-013 o_period  output  1  one-cycle pulse on each PWM period boundary.

Function
REQ-014 Prescaler counts 0..PRESCALE-1; step tick asserts on terminal count; PWM counter (PWM_W bits) increments per tick and wraps to 0.
REQ-015 Period boundary = tick while PWM counter is all-ones; o_period pulses that cycle; period = PRESCALE*2^PWM_W cycles.
REQ-016 Each channel has shadow (duty, mode), written on i_wr_en; i_wr_ch >= NUM_CH is ignored.
REQ-017 Shadow copies to active registers only at a period boundary; a write in the boundary cycle applies at the next boundary (glitch-free duty change).
REQ-018 Effective level L per channel: OFF -> 0; STATIC -> duty; BLINK -> duty during blink phase MSB=0, else 0; BREATHE -> ramp level.
REQ-019 o_led (pre-polarity) = 1 when PWM counter < L, except L all-ones -> constant 1; L=0 -> constant 0; output registered, 1-cycle latency from counter.
REQ-020 Blink counter (BLINK_W bits) shared by all channels, increments per period boundary, wraps.
REQ-021 BREATHE per-channel FSM, states UP/DOWN, level R (PWM_W bits), updated at period boundaries: UP: R<duty -> R+1, else -> DOWN; DOWN: R>0 -> R-1, else -> UP.
REQ-022 Duty 0 in BREATHE holds R=0 permanently; duty lowered below R while DOWN -> continue decrement; while UP -> go DOWN next boundary.
REQ-023 Mode change taking effect at a boundary resets that channel's R=0, state UP; duty-only change does not reset R.
REQ-024 All arithmetic unsigned, PWM_W bits, no overflow beyond all-ones; R never wraps.

Reset
REQ-025 i_rst clears prescaler, PWM, blink counters, all shadow/active registers (mode OFF, duty 0), R=0, state UP.
REQ-026 During/after reset o_led = inactive level (0, or all-ones if ACTIVE_LOW), o_period = 0.
REQ-027 Reset mid-period aborts the period; first boundary occurs PRESCALE*2^PWM_W cycles after release; writes during reset are dropped.

Configuration
REQ-028 Macro LED_PWM_BREATHE_EN defined: BREATHE mode and ramp FSM compiled in per REQ-021..023.
REQ-029 Macro absent: no ramp logic; mode 3 behaves exactly as STATIC.

Structure
REQ-030 Package led_pwm_pkg holds the mode enum (OFF/STATIC/BLINK/BREATHE), breathe state enum (UP/DOWN) and mode-width constant.
REQ-031 Sub-module led_pwm_channel, instantiated NUM_CH times: shadow/active regs, breathe FSM, compare; top holds prescaler, PWM, blink counters and write decode.

Verification (NUM_CH=3, PWM_W=4, PRESCALE=2, BLINK_W=3: period 32 cycles)
REQ-032 Reset, no writes -> o_led=3'b000 indefinitely, o_period every 32 cycles after release.
REQ-033 Write ch0 STATIC duty 4 -> from next boundary o_led[0] high 8 of every 32 cycles; duty 15 -> constant high; duty 0 -> constant low.
REQ-034 Write ch1 BLINK duty 15 -> o_led[1] high 4 periods (128 cycles), low 4 periods, repeating.
REQ-035 Write ch2 BREATHE duty 3 (macro on) -> per-period levels 0,1,2,3,3,2,1,0,0,1...; macro off -> constant level 3.
REQ-036 Write ch0 duty 8 on a boundary cycle -> old duty holds one more period; write to ch 3 -> no channel changes.
REQ-037 Assert i_rst mid-BREATHE ramp with ACTIVE_LOW=1 -> o_led=3'b111 next cycle, R=0, all modes OFF.
